// File: rtl/shake_pkg.sv
// shake_pkg: shared widths and FSM state encoding for the digest serializer
package shake_pkg;
    localparam int RATE_BITS  = 1088;
    localparam int DEF_WORD_W = 64;
    localparam int DEF_LEN_W  = 16;
    typedef enum logic [1:0] {IDLE, WAIT_BLK, STREAM, DONE} state_t;
endpackage

// File: rtl/digest_serializer.sv
// digest_serializer: streams out_len digest bytes as WORD_W words, pulling squeeze blocks on demand
// Ports: clk, reset (sync, active-low); start/out_len request a digest;
// more_req asks upstream for a block, block_valid/block_data deliver it;
// out_data/out_valid/out_ready/out_keep/out_last form the word stream; busy, done report status.
module digest_serializer
    import shake_pkg::*;
#(
    parameter int WIDTH_IN = RATE_BITS,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      out_len,
    output logic                  more_req,
    input  logic                  block_valid,
    input  logic [WIDTH_IN-1:0]   block_data,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W/8-1:0]   out_keep,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int NB     = WORD_W / 8;
    localparam int NWORDS = WIDTH_IN / WORD_W;
    localparam int IDX_W  = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam logic [LEN_W-1:0] NB_L     = LEN_W'(NB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [NB-1:0]    ALL_ONES = '1;
    state_t state, state_d;
    logic [LEN_W-1:0]    remaining;
    logic [IDX_W-1:0]    index;
    logic [WIDTH_IN-1:0] block_q;
    logic [WORD_W-1:0]   words [NWORDS];
    logic                hs;
    for (genvar g = 0; g < NWORDS; g++) begin : g_word
        assign words[g] = block_q[WIDTH_IN-1-g*WORD_W -: WORD_W];
    end
    assign out_valid = state == STREAM;
    assign hs        = out_valid && out_ready;
    assign out_data  = out_valid ? words[index] : '0;
    assign out_last  = out_valid && remaining <= NB_L;
    // a short tail keeps the top `remaining` bytes, i.e. the leading digest bytes
    assign out_keep  = !out_valid ? '0 : remaining < NB_L ? ~(ALL_ONES >> remaining) : ALL_ONES;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (start) state_d = out_len == '0 ? DONE : WAIT_BLK;
            WAIT_BLK: if (block_valid) state_d = STREAM;
            STREAM:   if (hs) state_d = out_last ? DONE : index == LAST_IDX ? WAIT_BLK : STREAM;
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            more_req  <= 1'b0;
            remaining <= '0;
            index     <= '0;
            block_q   <= '0;
        end else begin
            state    <= state_d;
            // registered so it marks only the entry cycle of each WAIT_BLK visit
            more_req <= state_d == WAIT_BLK && state != WAIT_BLK;
            if (state == IDLE && start)
                remaining <= out_len;
            if (state == WAIT_BLK && block_valid) begin
                block_q <= block_data;
                index   <= '0;
            end
            if (hs && !out_last) begin
                remaining <= remaining - NB_L;
                index     <= index == LAST_IDX ? '0 : index + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: directed self-checking bench for digest_serializer
module tb_digest_serializer;
    localparam int WIDTH_IN = 1088;
    localparam int WORD_W   = 64;
    localparam int LEN_W    = 16;
    localparam int NWORDS   = WIDTH_IN / WORD_W;
    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [LEN_W-1:0]    out_len = '0;
    logic                more_req;
    logic                block_valid = 1'b0;
    logic [WIDTH_IN-1:0] block_data = '0;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [7:0]          out_keep;
    logic                out_last;
    logic                busy;
    logic                done;
    int                  n_vec = 0;
    int                  n_err = 0;
    digest_serializer #(.WIDTH_IN(WIDTH_IN), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .out_len(out_len), .more_req(more_req),
        .block_valid(block_valid), .block_data(block_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_keep(out_keep),
        .out_last(out_last), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] word_of(input int b, input int i);
        return {8'(8'hA0 + b), 8'(i), 48'h0123_4567_89AB};
    endfunction
    function automatic logic [WIDTH_IN-1:0] blk(input int b);
        logic [WIDTH_IN-1:0] r;
        for (int i = 0; i < NWORDS; i++) r[WIDTH_IN-1-64*i -: 64] = word_of(b, i);
        return r;
    endfunction
    function automatic logic [7:0] exp_keep(input int rem);
        logic [7:0] m;
        for (int b = 0; b < 8; b++) m[7-b] = b < rem;
        return m;
    endfunction
    task automatic check_all_zero(input string tag);
        check({tag, "_more_req"}, 64'(more_req), 0);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_out_last"}, 64'(out_last), 0);
        check({tag, "_out_keep"}, 64'(out_keep), 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
    endtask
    // caller sits at a negedge; inputs change here and are sampled on the next posedge
    task automatic run(input int len, input int exp_words, input int exp_req, input logic [7:0] exp_last_keep,
                       input int stall_k, input int stall_n, input int junk_k, input int abort_k);
        int cyc = 1, k = 0, nreq = 0, nblk = 0, first_req = -1, stall_left = stall_n, rem;
        bit bv_prev = 0, fin_prev = 0, finished = 0, aborted = 0, valid_prev = 0;
        logic [7:0] last_keep = 8'h00;
        start = 1'b1;
        out_len = LEN_W'(len);
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && !aborted && cyc < 3000) begin
            block_valid = 1'b0;
            out_ready = 1'b1;
            if (bv_prev) check("blk_to_valid", 64'(out_valid), 1);
            if (fin_prev) check("done_latency", 64'(done), 1);
            if (valid_prev && k % NWORDS != 0 && !fin_prev) check("no_gap", 64'(out_valid), 1);
            valid_prev = 1'b0;
            fin_prev = 1'b0;
            if (more_req) begin
                nreq++;
                if (first_req < 0) first_req = cyc;
                block_valid = 1'b1;
                block_data = blk(nblk);
                nblk++;
            end
            if (done) begin
                finished = 1;
                check("done_busy", 64'(busy), 1);
                check("done_no_valid", 64'(out_valid), 0);
            end
            if (out_valid && k == abort_k) begin
                reset = 1'b0;
                @(negedge clk);
                check_all_zero("abort");
                reset = 1'b1;
                aborted = 1;
            end else if (out_valid) begin
                rem = len - 8 * k;
                check("busy", 64'(busy), 1);
                check("data", out_data, word_of(k / NWORDS, k % NWORDS));
                check("keep", 64'(out_keep), 64'(exp_keep(rem)));
                check("last", 64'(out_last), 64'(rem <= 8));
                if (k == junk_k) begin
                    block_valid = 1'b1;
                    block_data = blk(99);
                    junk_k = -1;
                end
                if (k == stall_k && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (out_last) last_keep = out_keep;
                    fin_prev = out_last;
                    valid_prev = !out_last;
                    k++;
                end
            end
            bv_prev = block_valid && !out_valid;
            if (!finished && !aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!aborted) begin
            check("finished", 64'(finished), 1);
            check("n_words", 64'(k), 64'(exp_words));
            check("n_more_req", 64'(nreq), 64'(exp_req));
            check("first_req_cycle", 64'(first_req), len > 0 ? 64'(1) : 64'(-1));
            if (len == 0) check("zero_len_done_cycle", 64'(cyc), 1);
            if (exp_words > 0) check("last_keep", 64'(last_keep), 64'(exp_last_keep));
            @(negedge clk);
            check("back_to_idle", 64'(busy), 0);
            check("done_one_cycle", 64'(done), 0);
        end
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        run(8, 1, 1, 8'hFF, -1, 0, -1, -1);
        run(0, 0, 0, 8'h00, -1, 0, -1, -1);
        run(20, 3, 1, 8'hF0, -1, 0, -1, -1);
        run(136, 17, 1, 8'hFF, -1, 0, -1, -1);
        run(137, 18, 2, 8'h80, -1, 0, -1, -1);
        run(24, 3, 1, 8'hFF, 1, 5, -1, -1);
        block_valid = 1'b1;
        block_data = blk(77);
        @(negedge clk);
        block_valid = 1'b0;
        check("idle_blk_busy", 64'(busy), 0);
        check("idle_blk_valid", 64'(out_valid), 0);
        run(20, 3, 1, 8'hF0, -1, 0, 1, -1);
        run(100, 0, 0, 8'h00, -1, 0, -1, 5);
        run(8, 1, 1, 8'hFF, -1, 0, -1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
